// File: rtl/gsau_ctrl.sv
// GSAU sequencer: weight-load/compute control, output-credit throttling of activation
// issue, destination tagging and a result buffer feeding the write-back path.
module gsau_ctrl #(
    parameter int DATA_W    = 512,
    parameter int TAG_W     = 8,
    parameter int N_ROWS    = 4,
    parameter int OUT_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] vdata,
    input  logic              valid,
    input  logic              nsvalid,
    input  logic [TAG_W-1:0]  nvdst,
    input  logic              weight,
    output logic              ready,
    output logic [DATA_W-1:0] array_in,
    output logic [DATA_W-1:0] array_in_partials,
    output logic              input_en,
    output logic              weight_en,
    output logic              partial_en,
    input  logic [DATA_W-1:0] array_output,
    input  logic              out_en,
    input  logic              fifo_has_space,
    output logic [DATA_W-1:0] psum,
    output logic [TAG_W-1:0]  wbdst,
    output logic              wb_valid,
    input  logic              output_ready,
    output logic [TAG_W-1:0]  vdst,
    output logic              svalid,
    output logic              busy,
    output logic              err
);
    localparam int PW = $clog2(OUT_DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = $clog2(N_ROWS + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WLOAD   = 2'd1,
        COMPUTE = 2'd2
    } state_t;

    state_t            state;
    logic [WW-1:0]     wcnt;
    logic [TAG_W-1:0]  tag_mem [OUT_DEPTH];
    logic [PW-1:0]     tag_wp, tag_rp;
    logic [CW-1:0]     tag_cnt;
    logic [DATA_W-1:0] res_data [OUT_DEPTH];
    logic [TAG_W-1:0]  res_tag [OUT_DEPTH];
    logic [PW-1:0]     res_wp, res_rp;
    logic [CW-1:0]     res_cnt;
    logic [CW:0]       occ;
    logic              credit, acc, tag_empty;
    logic              tag_push, tag_pop, res_pop;

    // Credits count every result the array may still produce plus those already buffered.
    assign occ       = {1'b0, tag_cnt} + {1'b0, res_cnt};
    assign credit    = occ < (CW + 1)'(OUT_DEPTH);
    assign tag_empty = tag_cnt == CW'(0);
    assign acc       = valid & nsvalid & ready;
    assign tag_push  = acc & ~weight & (state == COMPUTE);
    assign tag_pop   = out_en & ~tag_empty;
    assign res_pop   = wb_valid & output_ready;

    assign array_in_partials = '0;
    assign wb_valid = res_cnt != CW'(0);
    assign psum     = wb_valid ? res_data[res_rp] : '0;
    assign wbdst    = wb_valid ? res_tag[res_rp] : '0;
    assign vdst     = wbdst;
    assign svalid   = res_pop;
    assign busy     = (state != IDLE) | ~tag_empty | wb_valid;

    // Beat acceptance; never looks at valid/nsvalid so upstream can wait on it.
    always_comb begin
        ready = 1'b0;
        case (state)
            IDLE, WLOAD: ready = weight & fifo_has_space;
            COMPUTE: begin
                // A weight reload must wait until no activation result is still owed by the array.
                if (weight) ready = fifo_has_space & tag_empty;
                else        ready = fifo_has_space & credit;
            end
            default: ready = 1'b0;
        endcase
    end

    // Phase sequencing and registered issue strobes toward the array.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            wcnt       <= '0;
            array_in   <= '0;
            input_en   <= 1'b0;
            weight_en  <= 1'b0;
            partial_en <= 1'b0;
        end else begin
            input_en   <= acc & ~weight;
            partial_en <= acc & ~weight;
            weight_en  <= acc & weight;
            if (acc) array_in <= vdata;
            case (state)
                IDLE: if (acc) begin
                    wcnt  <= WW'(1);
                    state <= (N_ROWS == 1) ? COMPUTE : WLOAD;
                end
                WLOAD: if (acc) begin
                    wcnt <= wcnt + WW'(1);
                    if (wcnt == WW'(N_ROWS - 1)) state <= COMPUTE;
                end
                COMPUTE: if (acc & weight) begin
                    wcnt  <= WW'(1);
                    state <= (N_ROWS == 1) ? COMPUTE : WLOAD;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag FIFO pointers/count and sticky protocol error.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tag_wp  <= '0;
            tag_rp  <= '0;
            tag_cnt <= '0;
            err     <= 1'b0;
        end else begin
            if (tag_push) tag_wp <= tag_wp + PW'(1);
            if (tag_pop)  tag_rp <= tag_rp + PW'(1);
            tag_cnt <= tag_cnt + CW'(tag_push) - CW'(tag_pop);
            if (out_en & tag_empty) err <= 1'b1;
        end
    end

    // Result FIFO pointers/count; occupancy is bounded by the credit check.
    always_ff @(posedge CLK) begin
        if (RST) begin
            res_wp  <= '0;
            res_rp  <= '0;
            res_cnt <= '0;
        end else begin
            if (tag_pop) res_wp <= res_wp + PW'(1);
            if (res_pop) res_rp <= res_rp + PW'(1);
            res_cnt <= res_cnt + CW'(tag_pop) - CW'(res_pop);
        end
    end

    // Storage arrays; contents are only observed through valid counts.
    always_ff @(posedge CLK) begin
        if (tag_push) tag_mem[tag_wp] <= nvdst;
        if (tag_pop) begin
            res_data[res_wp] <= array_output;
            res_tag[res_wp]  <= tag_mem[tag_rp];
        end
    end
endmodule

// File: doc/gsau_ctrl.md
Name: gsau_ctrl

Overview:
- Sequencer between the Veggie File/Scoreboard issue path and the systolic array inside the GSAU.
- Runs weight-load and compute phases and throttles activation issue with an output-credit scheme, so the array (which cannot stall) never overruns buffering.
- Tags each result with its destination register and hands results to the WB buffer with a valid/ready handshake.

Parameters:
- DATA_W, 512, width of vector data, array rows and psum.
- TAG_W, 8, width of destination register index.
- N_ROWS, 4, weight beats per weight load.
- OUT_DEPTH, 4, maximum results in flight plus buffered (power of two, at least 2).

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous reset, active-high.
- vdata  in  DATA_W  operand/weight beat from Veggie File.
- valid  in  1  vdata valid.
- nsvalid  in  1  Scoreboard instruction valid.
- nvdst  in  TAG_W  destination register for the beat.
- weight  in  1  1 = weight beat, 0 = activation beat.
- ready  out  1  beat accepted when valid & nsvalid & ready.
- array_in  out  DATA_W  data to array.
- array_in_partials  out  DATA_W  partial-sum input; always 0.
- input_en  out  1  activation strobe.
- weight_en  out  1  weight strobe.
- partial_en  out  1  equals input_en.
- array_output  in  DATA_W  array result.
- out_en  in  1  array_output valid (single-cycle, not stallable).
- fifo_has_space  in  1  array input FIFO can take a beat.
- psum  out  DATA_W  result to WB buffer.
- wbdst  out  TAG_W  destination register of psum.
- wb_valid  out  1  psum valid.
- output_ready  in  1  WB buffer accepts.
- vdst  out  TAG_W  equals wbdst.
- svalid  out  1  completion pulse to Scoreboard: wb_valid & output_ready.
- busy  out  1  state != IDLE or any result outstanding.
- err  out  1  sticky: out_en arrived with no tag in flight.

Behaviour:
- Reset (all in the same cycle):
  - State goes to IDLE; counters, tag FIFO and result FIFO clear.
  - err = 0.
  - Registered outputs (array_in, input_en, weight_en, partial_en) = 0.
  - wb_valid = 0; psum and wbdst = 0.
- Reset mid-operation discards all in-flight tags and buffered results. Late out_en after reset sets err.
- acc = valid & nsvalid & ready.
- ready is combinational from state, registered counts, weight and fifo_has_space. It never depends on valid or nsvalid.
- occ = tag FIFO count + result FIFO count, both registered values. credit = (occ < OUT_DEPTH).
- States:
  - IDLE:
    - ready = weight & fifo_has_space.
    - On acc: wcnt = 1; go to WLOAD, or straight to COMPUTE if N_ROWS == 1.
  - WLOAD:
    - ready = weight & fifo_has_space.
    - On acc: wcnt++. When wcnt reaches N_ROWS, go to COMPUTE.
    - Activation beats are held off (ready = 0).
  - COMPUTE, activation beat:
    - ready = ~weight & credit & fifo_has_space.
    - On acc: push nvdst into the tag FIFO.
  - COMPUTE, weight beat (reload):
    - ready = weight & fifo_has_space & (tag FIFO count == 0).
    - On acc: wcnt = 1 and go to WLOAD. Buffered results keep draining.
- Issue latency: a beat accepted in cycle t drives array_in = vdata in cycle t+1.
  - input_en = 1 (activation) or weight_en = 1 (weight) for exactly one cycle per beat.
  - Strobes are 0 otherwise; array_in holds its last value.
- Collect path, when out_en is high in cycle u:
  - Pop the tag FIFO head.
  - Push {array_output, tag} into the result FIFO; visible on psum/wbdst/wb_valid at cycle u+1 at the earliest.
  - out_en with an empty tag FIFO sets err and pushes nothing.
- Result FIFO:
  - First-word-fall-through on the registered head: wb_valid = not empty.
  - Pops on wb_valid & output_ready.
  - psum and wbdst stay stable while wb_valid & ~output_ready.
- Credit timing:
  - A pop in cycle t frees its credit only from cycle t+1; there is no same-cycle bypass.
  - Simultaneous issue, out_en and WB pop in one cycle are legal and update the counts consistently.
  - occ never exceeds OUT_DEPTH, so the result FIFO never overflows.
- Results leave in issue order; tags match 1:1 with activations.

Test Plan:
- Weight load: RST, then 4 weight beats with valid = nsvalid = 1 back-to-back.
  - Required: weight_en high in cycles 1–4 after the first acc.
  - Required: state COMPUTE after the 4th beat; ready low for an activation beat sent during WLOAD.
- Basic compute: after the load, issue one activation with nvdst = 8'h05; array returns out_en three cycles later with array_output = 512'hA5 repeated.
  - Required: wb_valid the next cycle with psum = that value and wbdst = vdst = 8'h05.
  - Required: svalid pulses for one cycle with output_ready = 1.
- Backpressure / credits: output_ready = 0; issue 6 activations with tags 1–6.
  - Required: exactly 4 accepted and ready low afterwards.
  - Required: after output_ready = 1, results emerge in order 1, 2, 3, 4, and ready returns one cycle after the first pop.
- Reload hazard: tags in flight, then a weight beat is presented.
  - Required: ready stays 0 until the last out_en pops the tag FIFO, then the beat is accepted and state goes to WLOAD.
- Protocol error and reset: out_en in IDLE with no tags.
  - Required: err = 1 and stays 1.
  - Required: RST mid-compute with 2 tags in flight clears wb_valid, busy and err the next cycle, and ready reflects IDLE.
